// File: rtl/ldpc_status_checker.sv
// Checks LDPC core status words against in-order expectations and emits one report per block.
// Latency: status accepted in cycle N -> registered report in N+1; one status per cycle sustained.
// Backpressure: s_status_tready = !rpt_valid || rpt_ready (1-deep output register); exp_ready = !full.
//
// Ports:
//   clk, rst                        clock, async active-high reset
//   exp_*                           expectation push (valid/ready) with expected fields + max_iter
//   s_status_*                      40-bit status stream from the core (valid/ready)
//   rpt_*                           per-block report (valid/ready), held stable until accepted
//   err_clr, err_*                  sticky error flags and their clear strobe
//   blk_cnt, pass_cnt, outstanding  wrap-around counters and current expectation occupancy
module ldpc_status_checker #(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 65535
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     exp_valid,
  output logic                     exp_ready,
  input  logic [7:0]               exp_id,
  input  logic [2:0]               exp_bg,
  input  logic [2:0]               exp_z_set,
  input  logic [2:0]               exp_z_j,
  input  logic [5:0]               exp_mb,
  input  logic [5:0]               exp_max_iter,
  input  logic [39:0]              s_status_tdata,
  input  logic                     s_status_tvalid,
  output logic                     s_status_tready,
  output logic                     rpt_valid,
  input  logic                     rpt_ready,
  output logic [7:0]               rpt_id,
  output logic [5:0]               rpt_iter,
  output logic                     rpt_pass,
  output logic                     rpt_hard_op,
  output logic [5:0]               rpt_mismatch,
  output logic                     rpt_unexpected,
  input  logic                     err_clr,
  output logic                     err_mismatch,
  output logic                     err_unexpected,
  output logic                     err_timeout,
  output logic [31:0]              blk_cnt,
  output logic [31:0]              pass_cnt,
  output logic [$clog2(DEPTH):0]   outstanding
);

  localparam int AW = $clog2(DEPTH);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT);

  typedef struct packed {
    logic [7:0] id;
    logic [2:0] bg;
    logic [2:0] z_set;
    logic [2:0] z_j;
    logic [5:0] mb;
    logic [5:0] max_iter;
  } exp_t;

  // Expectation FIFO: pointers carry one extra wrap bit so full/empty fall out of the difference.
  exp_t        mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        empty;
  logic        full;
  logic        push;
  logic        accept;
  logic        pop;
  exp_t        head;

  assign outstanding = wr_ptr - rd_ptr;
  assign empty       = (outstanding == '0);
  assign full        = (outstanding == (AW+1)'(DEPTH));
  assign exp_ready   = !full;
  assign push        = exp_valid && exp_ready;

  assign s_status_tready = !rpt_valid || rpt_ready;
  assign accept          = s_status_tvalid && s_status_tready;
  // No bypass: a status meeting an empty FIFO is unexpected even if a push lands this cycle.
  assign pop             = accept && !empty;
  assign head            = mem[rd_ptr[AW-1:0]];

  // Status word unpack
  logic [7:0] st_id;
  logic [5:0] st_iter;
  logic       st_pass;
  logic       st_hard_op;
  logic [2:0] st_bg;
  logic [2:0] st_z_set;
  logic [2:0] st_z_j;
  logic [5:0] st_mb;
  logic       unused_status_bits;

  assign st_id      = s_status_tdata[7:0];
  assign st_iter    = s_status_tdata[13:8];
  assign st_pass    = s_status_tdata[14];
  assign st_hard_op = s_status_tdata[18];
  assign st_bg      = s_status_tdata[22:20];
  assign st_z_set   = s_status_tdata[25:23];
  assign st_z_j     = s_status_tdata[28:26];
  assign st_mb      = s_status_tdata[34:29];
  // Termination-mode echoes, DEC_OP and reserved bits are carried but not checked.
  assign unused_status_bits = ^{s_status_tdata[39:35], s_status_tdata[19], s_status_tdata[17:15]};

  logic [5:0] mismatch;
  assign mismatch = {st_iter > head.max_iter,
                     st_mb    != head.mb,
                     st_z_j   != head.z_j,
                     st_z_set != head.z_set,
                     st_bg    != head.bg,
                     st_id    != head.id};

  // Storage has no reset; validity is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= '{id: exp_id, bg: exp_bg, z_set: exp_z_set, z_j: exp_z_j,
                               mb: exp_mb, max_iter: exp_max_iter};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Watchdog: counts idle cycles with blocks in flight, saturates at TIMEOUT.
  logic [WW-1:0] wd_cnt;
  logic          wd_fire;
  assign wd_fire = !accept && !empty && (wd_cnt == WD_MAX - 1'b1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt <= '0;
    end else if (accept || empty) begin
      wd_cnt <= '0;
    end else if (wd_cnt != WD_MAX) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  // Report register, counters and sticky flags (a set event outranks err_clr).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rpt_valid      <= 1'b0;
      rpt_id         <= '0;
      rpt_iter       <= '0;
      rpt_pass       <= 1'b0;
      rpt_hard_op    <= 1'b0;
      rpt_mismatch   <= '0;
      rpt_unexpected <= 1'b0;
      blk_cnt        <= '0;
      pass_cnt       <= '0;
      err_mismatch   <= 1'b0;
      err_unexpected <= 1'b0;
      err_timeout    <= 1'b0;
    end else begin
      if (accept) begin
        rpt_valid      <= 1'b1;
        rpt_id         <= st_id;
        rpt_iter       <= st_iter;
        rpt_pass       <= st_pass;
        rpt_hard_op    <= st_hard_op;
        rpt_mismatch   <= empty ? 6'b0 : mismatch;
        rpt_unexpected <= empty;
        blk_cnt        <= blk_cnt + 32'd1;
        pass_cnt       <= pass_cnt + {31'b0, st_pass};
      end else if (rpt_ready) begin
        rpt_valid <= 1'b0;
      end

      if (pop && (mismatch != 6'b0)) err_mismatch <= 1'b1;
      else if (err_clr)              err_mismatch <= 1'b0;

      if (accept && empty) err_unexpected <= 1'b1;
      else if (err_clr)    err_unexpected <= 1'b0;

      if (wd_fire)      err_timeout <= 1'b1;
      else if (err_clr) err_timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ldpc_status_checker.sv
module tb_ldpc_status_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        exp_valid;
  logic        exp_ready;
  logic [7:0]  exp_id;
  logic [2:0]  exp_bg;
  logic [2:0]  exp_z_set;
  logic [2:0]  exp_z_j;
  logic [5:0]  exp_mb;
  logic [5:0]  exp_max_iter;
  logic [39:0] s_status_tdata;
  logic        s_status_tvalid;
  logic        s_status_tready;
  logic        rpt_valid;
  logic        rpt_ready;
  logic [7:0]  rpt_id;
  logic [5:0]  rpt_iter;
  logic        rpt_pass;
  logic        rpt_hard_op;
  logic [5:0]  rpt_mismatch;
  logic        rpt_unexpected;
  logic        err_clr;
  logic        err_mismatch;
  logic        err_unexpected;
  logic        err_timeout;
  logic [31:0] blk_cnt;
  logic [31:0] pass_cnt;
  logic [4:0]  outstanding;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ldpc_status_checker #(.DEPTH(16), .TIMEOUT(10)) dut (
    .clk(clk), .rst(rst),
    .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_id(exp_id), .exp_bg(exp_bg),
    .exp_z_set(exp_z_set), .exp_z_j(exp_z_j), .exp_mb(exp_mb), .exp_max_iter(exp_max_iter),
    .s_status_tdata(s_status_tdata), .s_status_tvalid(s_status_tvalid),
    .s_status_tready(s_status_tready),
    .rpt_valid(rpt_valid), .rpt_ready(rpt_ready), .rpt_id(rpt_id), .rpt_iter(rpt_iter),
    .rpt_pass(rpt_pass), .rpt_hard_op(rpt_hard_op), .rpt_mismatch(rpt_mismatch),
    .rpt_unexpected(rpt_unexpected),
    .err_clr(err_clr), .err_mismatch(err_mismatch), .err_unexpected(err_unexpected),
    .err_timeout(err_timeout), .blk_cnt(blk_cnt), .pass_cnt(pass_cnt),
    .outstanding(outstanding)
  );

  function automatic logic [39:0] mk_status(input logic [7:0] id, input logic [5:0] iter,
                                            input logic pass, input logic hard,
                                            input logic [2:0] bg, input logic [2:0] zs,
                                            input logic [2:0] zj, input logic [5:0] mb);
    return {5'b0, mb, zj, zs, bg, 1'b0, hard, 3'b0, pass, iter, id};
  endfunction

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] id, input logic [2:0] bg, input logic [2:0] zs,
                      input logic [2:0] zj, input logic [5:0] mb, input logic [5:0] mi);
    exp_valid = 1'b1; exp_id = id; exp_bg = bg; exp_z_set = zs; exp_z_j = zj;
    exp_mb = mb; exp_max_iter = mi;
    tick();
    exp_valid = 1'b0;
  endtask

  task automatic send(input logic [39:0] w);
    s_status_tvalid = 1'b1; s_status_tdata = w;
    tick();
    s_status_tvalid = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  task automatic test_reset();
    n_chk++; if (exp_ready !== 1'b1) begin n_err++; $display("FAIL reset_exp_ready got %0b want 1", exp_ready); end
    n_chk++; if (s_status_tready !== 1'b1) begin n_err++; $display("FAIL reset_tready got %0b want 1", s_status_tready); end
    n_chk++; if (rpt_valid !== 1'b0) begin n_err++; $display("FAIL reset_rpt_valid got %0b want 0", rpt_valid); end
    n_chk++; if ({blk_cnt, pass_cnt} !== 64'd0) begin n_err++; $display("FAIL reset_counters got %0d/%0d want 0/0", blk_cnt, pass_cnt); end
    n_chk++; if (outstanding !== 5'd0) begin n_err++; $display("FAIL reset_outstanding got %0d want 0", outstanding); end
    n_chk++; if ({err_mismatch, err_unexpected, err_timeout} !== 3'b000) begin n_err++; $display("FAIL reset_flags got %b want 000", {err_mismatch, err_unexpected, err_timeout}); end
    n_chk++; if ({rpt_id, rpt_iter, rpt_pass, rpt_hard_op, rpt_mismatch, rpt_unexpected} !== 23'd0) begin n_err++; $display("FAIL reset_rpt_fields got nonzero want 0"); end
  endtask

  task automatic test_basic();
    push(8'd5, 3'd1, 3'd2, 3'd3, 6'd8, 6'd32);
    n_chk++; if (outstanding !== 5'd1) begin n_err++; $display("FAIL basic_occ_after_push got %0d want 1", outstanding); end
    send(mk_status(8'd5, 6'd7, 1'b1, 1'b1, 3'd1, 3'd2, 3'd3, 6'd8));
    n_chk++; if (rpt_valid !== 1'b1) begin n_err++; $display("FAIL basic_rpt_valid got %0b want 1", rpt_valid); end
    n_chk++; if (rpt_id !== 8'd5 || rpt_iter !== 6'd7) begin n_err++; $display("FAIL basic_id_iter got %0d/%0d want 5/7", rpt_id, rpt_iter); end
    n_chk++; if (rpt_pass !== 1'b1 || rpt_hard_op !== 1'b1) begin n_err++; $display("FAIL basic_pass_hard got %0b/%0b want 1/1", rpt_pass, rpt_hard_op); end
    n_chk++; if (rpt_mismatch !== 6'd0 || rpt_unexpected !== 1'b0) begin n_err++; $display("FAIL basic_mismatch got %b/%0b want 000000/0", rpt_mismatch, rpt_unexpected); end
    n_chk++; if (blk_cnt !== 32'd1 || pass_cnt !== 32'd1) begin n_err++; $display("FAIL basic_counts got %0d/%0d want 1/1", blk_cnt, pass_cnt); end
    n_chk++; if (outstanding !== 5'd0) begin n_err++; $display("FAIL basic_occ got %0d want 0", outstanding); end
    tick();
    n_chk++; if (rpt_valid !== 1'b0) begin n_err++; $display("FAIL basic_rpt_drop got %0b want 0", rpt_valid); end
  endtask

  task automatic test_mismatch();
    push(8'd5, 3'd1, 3'd2, 3'd3, 6'd8, 6'd32);
    send(mk_status(8'd6, 6'd40, 1'b0, 1'b0, 3'd1, 3'd2, 3'd3, 6'd8));
    n_chk++; if (rpt_mismatch !== 6'b100001) begin n_err++; $display("FAIL mm_bits got %b want 100001", rpt_mismatch); end
    n_chk++; if (err_mismatch !== 1'b1) begin n_err++; $display("FAIL mm_sticky got %0b want 1", err_mismatch); end
    n_chk++; if (blk_cnt !== 32'd2 || pass_cnt !== 32'd1) begin n_err++; $display("FAIL mm_counts got %0d/%0d want 2/1", blk_cnt, pass_cnt); end
    pulse_clr();
    n_chk++; if (err_mismatch !== 1'b0) begin n_err++; $display("FAIL mm_clr got %0b want 0", err_mismatch); end
    n_chk++; if (blk_cnt !== 32'd2) begin n_err++; $display("FAIL mm_clr_blk got %0d want 2", blk_cnt); end
  endtask

  task automatic test_unexpected();
    exp_valid = 1'b1; exp_id = 8'd9; exp_bg = 3'd0; exp_z_set = 3'd0; exp_z_j = 3'd0;
    exp_mb = 6'd0; exp_max_iter = 6'd63;
    s_status_tvalid = 1'b1; s_status_tdata = mk_status(8'd9, 6'd1, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 6'd0);
    tick();
    exp_valid = 1'b0; s_status_tvalid = 1'b0;
    n_chk++; if (rpt_unexpected !== 1'b1 || rpt_mismatch !== 6'd0) begin n_err++; $display("FAIL unexp_rpt got %0b/%b want 1/000000", rpt_unexpected, rpt_mismatch); end
    n_chk++; if (err_unexpected !== 1'b1) begin n_err++; $display("FAIL unexp_sticky got %0b want 1", err_unexpected); end
    n_chk++; if (outstanding !== 5'd1) begin n_err++; $display("FAIL unexp_occ got %0d want 1", outstanding); end
    n_chk++; if (blk_cnt !== 32'd3) begin n_err++; $display("FAIL unexp_blk got %0d want 3", blk_cnt); end
    send(mk_status(8'd9, 6'd1, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 6'd0));
    n_chk++; if (rpt_unexpected !== 1'b0 || rpt_mismatch !== 6'd0 || rpt_id !== 8'd9) begin n_err++; $display("FAIL unexp_drain got u=%0b m=%b id=%0d want 0/000000/9", rpt_unexpected, rpt_mismatch, rpt_id); end
    n_chk++; if (outstanding !== 5'd0) begin n_err++; $display("FAIL unexp_drain_occ got %0d want 0", outstanding); end
  endtask

  task automatic test_full_drain();
    int sent = 0;
    int recv = 0;
    int cyc = 0;
    logic [7:0] k;
    for (int i = 0; i < 17; i++) begin
      k = 8'(i);
      n_chk++; if (exp_ready !== (i < 16)) begin n_err++; $display("FAIL full_ready_%0d got %0b want %0b", i, exp_ready, (i < 16)); end
      push(8'd16 + k, k[2:0], ~k[2:0], 3'd5, k[5:0], 6'd20);
    end
    n_chk++; if (outstanding !== 5'd16 || exp_ready !== 1'b0) begin n_err++; $display("FAIL full_occ got %0d/%0b want 16/0", outstanding, exp_ready); end
    while (recv < 16 && cyc < 400) begin
      rpt_ready = 1'($urandom_range(0, 1));
      s_status_tvalid = (sent < 16);
      k = 8'(sent);
      s_status_tdata = mk_status(8'd16 + k, {2'b0, k[3:0]}, k[0], 1'b0, k[2:0], ~k[2:0], 3'd5, k[5:0]);
      #1;
      if (rpt_valid && rpt_ready) begin
        n_chk++; if (rpt_id !== 8'(16 + recv) || rpt_mismatch !== 6'd0 || rpt_unexpected !== 1'b0) begin n_err++; $display("FAIL drain_rpt_%0d got id=%0d m=%b u=%0b want id=%0d m=000000 u=0", recv, rpt_id, rpt_mismatch, rpt_unexpected, 16 + recv); end
        recv++;
      end
      if (s_status_tvalid && s_status_tready) sent++;
      tick();
      cyc++;
    end
    s_status_tvalid = 1'b0; rpt_ready = 1'b1;
    n_chk++; if (recv !== 16) begin n_err++; $display("FAIL drain_count got %0d want 16", recv); end
    n_chk++; if (rpt_valid !== 1'b0) begin n_err++; $display("FAIL drain_no_dup got rpt_valid=%0b want 0", rpt_valid); end
    n_chk++; if (outstanding !== 5'd0) begin n_err++; $display("FAIL drain_occ got %0d want 0", outstanding); end
    n_chk++; if (blk_cnt !== 32'd20 || pass_cnt !== 32'd9) begin n_err++; $display("FAIL drain_counts got %0d/%0d want 20/9", blk_cnt, pass_cnt); end
    n_chk++; if (err_mismatch !== 1'b0) begin n_err++; $display("FAIL drain_err_mm got %0b want 0", err_mismatch); end
  endtask

  task automatic test_timeout();
    pulse_clr();
    n_chk++; if (err_timeout !== 1'b0) begin n_err++; $display("FAIL to_pre_clr got %0b want 0", err_timeout); end
    push(8'd40, 3'd0, 3'd0, 3'd0, 6'd0, 6'd10);
    repeat (9) tick();
    n_chk++; if (err_timeout !== 1'b0) begin n_err++; $display("FAIL to_early got %0b want 0 after 9 idle", err_timeout); end
    tick();
    n_chk++; if (err_timeout !== 1'b1) begin n_err++; $display("FAIL to_fire got %0b want 1 after 10 idle", err_timeout); end
    send(mk_status(8'd40, 6'd1, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 6'd0));
    pulse_clr();
    n_chk++; if (err_timeout !== 1'b0) begin n_err++; $display("FAIL to_clr got %0b want 0", err_timeout); end
    push(8'd41, 3'd0, 3'd0, 3'd0, 6'd0, 6'd10);
    repeat (8) tick();
    send(mk_status(8'd41, 6'd1, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 6'd0));
    repeat (5) tick();
    n_chk++; if (err_timeout !== 1'b0 || outstanding !== 5'd0) begin n_err++; $display("FAIL to_serviced got %0b/%0d want 0/0", err_timeout, outstanding); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) push(8'(50 + i), 3'd0, 3'd0, 3'd0, 6'd0, 6'd10);
    rpt_ready = 1'b0;
    send(mk_status(8'd50, 6'd1, 1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 6'd0));
    n_chk++; if (rpt_valid !== 1'b1 || outstanding !== 5'd3) begin n_err++; $display("FAIL rst_pre got %0b/%0d want 1/3", rpt_valid, outstanding); end
    #2 rst = 1'b1;
    #1;
    n_chk++; if (rpt_valid !== 1'b0 || outstanding !== 5'd0) begin n_err++; $display("FAIL rst_async got %0b/%0d want 0/0", rpt_valid, outstanding); end
    n_chk++; if (exp_ready !== 1'b1 || s_status_tready !== 1'b1) begin n_err++; $display("FAIL rst_ready got %0b/%0b want 1/1", exp_ready, s_status_tready); end
    n_chk++; if (blk_cnt !== 32'd0 || pass_cnt !== 32'd0 || rpt_id !== 8'd0) begin n_err++; $display("FAIL rst_regs got %0d/%0d/%0d want 0/0/0", blk_cnt, pass_cnt, rpt_id); end
    tick();
    rst = 1'b0; rpt_ready = 1'b1;
    tick();
    send(mk_status(8'd51, 6'd1, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 6'd0));
    n_chk++; if (rpt_unexpected !== 1'b1 || outstanding !== 5'd0) begin n_err++; $display("FAIL rst_after got %0b/%0d want 1/0", rpt_unexpected, outstanding); end
  endtask

  initial begin
    rst = 1'b1; exp_valid = 1'b0; exp_id = '0; exp_bg = '0; exp_z_set = '0; exp_z_j = '0;
    exp_mb = '0; exp_max_iter = '0; s_status_tdata = '0; s_status_tvalid = 1'b0;
    rpt_ready = 1'b1; err_clr = 1'b0;
    repeat (3) tick();
    test_reset();
    rst = 1'b0;
    tick();
    test_basic();
    test_mismatch();
    test_unexpected();
    test_full_drain();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ldpc_status_checker.md
# ldpc_status_checker

Receives the decoder/encoder status stream returned by the LDPC core and unpacks it into named fields. It checks each status word against the control parameters issued for that block, which are held in an in-order expectation FIFO. It emits one report per block and keeps sticky error flags and wrap-around counters for the loop wrapper's register map. It is the return-path counterpart of the control-word packer and sits between the core's status port and the wrapper's result/CSR logic.

## Interface
- `DEPTH`, 16: expectation FIFO entries (power of two, ≥2).
- `TIMEOUT`, 65535: idle cycles with outstanding blocks before the watchdog fires.
- `clk` in 1: the single clock.
- `rst` in 1: reset, asynchronous and active-high.
- `exp_valid` in 1: expectation push request.
- `exp_ready` out 1: high when the FIFO is not full.
- `exp_id` in 8: expected `ID`.
- `exp_bg` in 3: expected `BG`.
- `exp_z_set` in 3: expected `Z_SET`.
- `exp_z_j` in 3: expected `Z_J`.
- `exp_mb` in 6: expected `MB`.
- `exp_max_iter` in 6: `MAX_ITERATIONS` that was issued.
- `s_status_tdata` in 40: status word.
- `s_status_tvalid` in 1: status valid.
- `s_status_tready` out 1: status ready.
- `rpt_valid` in/out: out 1, report valid.
- `rpt_ready` in 1: report accepted downstream.
- `rpt_id` out 8: `ID` unpacked from status.
- `rpt_iter` out 6: iterations used.
- `rpt_pass` out 1: parity pass.
- `rpt_hard_op` out 1: `HARD_OP` echo.
- `rpt_mismatch` out 6: per-field mismatch flags.
- `rpt_unexpected` out 1: status arrived while the FIFO was empty.
- `err_clr` in 1: clears sticky flags; counters are not affected.
- `err_mismatch` out 1: sticky.
- `err_unexpected` out 1: sticky.
- `err_timeout` out 1: sticky.
- `blk_cnt` out 32: reports issued.
- `pass_cnt` out 32: reports with `rpt_pass`=1.
- `outstanding` out $clog2(DEPTH)+1: current FIFO occupancy.

## Operation
- Status word layout:
  - [7:0] `ID`
  - [13:8] iterations
  - [14] `PASS`
  - [15] `TERM_ON_NO_CHANGE`
  - [16] `TERM_ON_PASS`
  - [17] `INCLUDE_PARITY_OP`
  - [18] `HARD_OP`
  - [19] `DEC_OP`
  - [22:20] `BG`
  - [25:23] `Z_SET`
  - [28:26] `Z_J`
  - [34:29] `MB`
  - [39:35] reserved, ignored.
- Push: on `exp_valid && exp_ready`, the record is written at the tail. `exp_ready` = !full.
- Status accept: happens on `s_status_tvalid && s_status_tready`. `s_status_tready` = !`rpt_valid` || `rpt_ready` (1-deep output register).
- On accept with the FIFO non-empty:
  - Pop the head.
  - Set `rpt_mismatch` bit by bit:
    - [0] ID differs
    - [1] BG differs
    - [2] Z_SET differs
    - [3] Z_J differs
    - [4] MB differs
    - [5] iterations > `exp_max_iter`
  - `rpt_unexpected`=0.
- On accept with the FIFO empty:
  - No pop.
  - `rpt_unexpected`=1 and `rpt_mismatch`=6'b0.
  - `err_unexpected` is set.
- Push and accept in the same cycle:
  - Both take effect.
  - Occupancy is unchanged.
  - The comparison uses the pre-cycle head.
  - If the FIFO was empty before the cycle, the result is unexpected; the FIFO has no bypass.
- Sticky flags: `err_mismatch` sets when a report with any `rpt_mismatch` bit set is loaded.
- Counters, updated when a report is loaded:
  - `blk_cnt` += 1.
  - `pass_cnt` += `PASS`.
  - Both are 32-bit and wrap modulo 2^32.
- Watchdog:
  - The cycle counter increments while `outstanding`>0 and no accept occurs.
  - It clears on accept or when `outstanding`==0.
  - When it reaches `TIMEOUT`, `err_timeout` sets and the counter holds.
- `err_clr`:
  - Clears the three sticky flags next cycle.
  - A set event in the same cycle wins, so the flag stays 1.

## Timing
- Reset values:
  - `exp_ready`=1.
  - `s_status_tready`=1.
  - `rpt_valid`=0.
  - All `rpt_*` fields, flags, counters, `outstanding` and the watchdog = 0.
  - The FIFO is emptied.
- Latency: status accepted in cycle N gives `rpt_valid`=1 in N+1 with all fields registered. `outstanding` and `exp_ready` reflect the pop/push in N+1.
- Throughput: one status per cycle while `rpt_ready`=1.
- `rpt_valid` and the `rpt_*` fields hold stable until `rpt_ready`.
- Reset mid-operation: everything returns to reset values immediately. Outstanding expectations are discarded and a report held in the output register is dropped.
- Full FIFO: a push is refused, with no overwrite. A push and a pop in the same cycle while full is impossible, because `exp_ready`=0.

## Test plan
- Push ID=5, BG=1, Z_SET=2, Z_J=3, MB=8, max_iter=32; then send status with identical fields, iter=7, PASS=1.
  - Required: report 1 cycle later with mismatch=0, `blk_cnt`=1, `pass_cnt`=1, `outstanding`=0.
- Push ID=5; send status with ID=6 and iter=40 against max_iter=32.
  - Required: `rpt_mismatch`=6'b100001 and `err_mismatch`=1.
  - Then pulse `err_clr`; `err_mismatch`=0 and `blk_cnt` unchanged.
- Status with the FIFO empty, plus a push of ID=9 in the same cycle.
  - Required: `rpt_unexpected`=1, `err_unexpected`=1, `outstanding`=1.
- Push `DEPTH`+1 records.
  - Required: `exp_ready`=0 after `DEPTH`; the extra push is ignored.
  - Then drain `DEPTH` statuses in order with IDs matching and `rpt_ready` toggling randomly; zero mismatches and no lost or duplicated report.
- `TIMEOUT`=10; push 1 record and send no status.
  - Required: `err_timeout`=1 after exactly 10 idle cycles.
  - A second run that sends status at cycle 9 leaves the flag 0.
- Assert `rst` with 3 outstanding records and `rpt_valid`=1.
  - Required: all outputs return to reset values, and the next status reports unexpected.
